// File: rtl/result_sender.sv
// result_sender: reads the result matrix from result memory and sends it to the HPS as packed words over a 4-phase req/ack handshake
// clk, rst         : clock and synchronous active-high reset
// ready, overflow  : result-valid level and overflow flag from control_unit
// mem_addr         : result memory read address
// mem_rdata        : read data, one cycle after mem_addr
// hps_req, hps_ack : 4-phase handshake with the HPS
// hps_data         : packed word, PACK elements with element 0 in the low byte
// hps_last         : the current word holds the final element
// hps_ovf          : overflow flag latched when the transfer starts
// busy, done       : transfer in progress / full matrix delivered
module result_sender #(
    parameter int DATA_W  = 8,
    parameter int N_ELEMS = 25,
    parameter int ADDR_W  = 5,
    parameter int PACK    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic                     overflow,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     hps_req,
    output logic                     hps_ack,
    output logic [PACK*DATA_W-1:0]   hps_data,
    output logic                     hps_last,
    output logic                     hps_ovf,
    output logic                     busy,
    output logic                     done
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [ADDR_W-1:0] LAST_E = ADDR_W'(N_ELEMS - 1);
    typedef enum logic [2:0] {IDLE, LOAD, OFFER, ACK, DONE} state_t;
    state_t state;
    logic iss_v, cap_v, word_last, iss_end, cap_end;
    logic [ADDR_W-1:0] cap_e;
    logic [LW-1:0] iss_lane, cap_lane;
    logic [PACK-1:0][DATA_W-1:0] pack_buf;
    // iss_* describes the address presented this cycle, cap_* the element whose data is on mem_rdata now
    always_comb begin
        iss_lane = LW'(mem_addr % ADDR_W'(PACK));
        cap_lane = LW'(cap_e % ADDR_W'(PACK));
        iss_end  = iss_lane == LW'(PACK - 1) || mem_addr == LAST_E;
        cap_end  = cap_lane == LW'(PACK - 1) || cap_e == LAST_E;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            hps_ack   <= 1'b0;
            hps_data  <= '0;
            hps_last  <= 1'b0;
            hps_ovf   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            iss_v     <= 1'b0;
            cap_v     <= 1'b0;
            cap_e     <= '0;
            word_last <= 1'b0;
            pack_buf  <= '0;
        end else begin
            case (state)
                IDLE: if (ready) begin
                    hps_ovf  <= overflow;
                    mem_addr <= '0;
                    iss_v    <= 1'b1;
                    cap_v    <= 1'b0;
                    pack_buf <= '0;
                    busy     <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    cap_v <= iss_v;
                    cap_e <= mem_addr;
                    // mem_addr parks on the word's final element so it never runs past N_ELEMS-1
                    if (iss_v) begin
                        if (iss_end) iss_v <= 1'b0;
                        else mem_addr <= mem_addr + 1'b1;
                    end
                    if (cap_v) begin
                        pack_buf[cap_lane] <= mem_rdata;
                        if (cap_end) begin
                            word_last <= cap_e == LAST_E;
                            cap_v     <= 1'b0;
                            state     <= OFFER;
                        end
                    end
                end
                OFFER: if (hps_req) begin
                    hps_data <= pack_buf;
                    hps_last <= word_last;
                    hps_ack  <= 1'b1;
                    state    <= ACK;
                end
                ACK: if (!hps_req) begin
                    hps_ack <= 1'b0;
                    if (word_last) begin
                        hps_last <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        pack_buf <= '0;
                        mem_addr <= mem_addr + 1'b1;
                        iss_v    <= 1'b1;
                        state    <= LOAD;
                    end
                end
                // holding here until ready drops keeps one result from being sent twice
                DONE: if (!ready) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
